cussen_repeat: RTL and testbench

- Repeat-aware vector-by-scalar multiplier: computes outN = inN * scalar for nine 8-bit lanes.
- Uses one shared multiplier and multiplies each distinct input value only once. Lanes that repeat a value reuse the stored result.
- Free-running: repeatedly snapshots the inputs, deduplicates, multiplies the unique values, then writes all nine outputs.
- Sits as a datapath leaf beside the cussen compute blocks; it needs no start/valid handshake.

---
 rtl/cussen_pkg.sv | 19 +
 rtl/cussen_dedup_scan.sv | 57 +++++
 rtl/cussen_repeat.sv | 126 ++++++++++++
 tb/tb_cussen_repeat.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cussen_pkg.sv
// Shared constants and types for the repeat-aware vector-by-scalar multiplier.
// State encodings are plain localparams so older tools can consume them.
package cussen_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned LANES  = 9;
   localparam int unsigned IDX_W  = 4;

   localparam logic [1:0] StCapture = 2'd0;
   localparam logic [1:0] StScan    = 2'd1;
   localparam logic [1:0] StMult    = 2'd2;
   localparam logic [1:0] StWrite   = 2'd3;

   typedef logic [DATA_W-1:0]            data_t;
   typedef logic [IDX_W-1:0]             idx_t;
   typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;
   typedef logic [LANES-1:0][IDX_W-1:0]  ptr_vec_t;

endpackage

// File: rtl/cussen_dedup_scan.sv
// Builds the table of distinct lane values, one lane per enabled cycle, and
// records for every lane which table entry holds its value.
module cussen_dedup_scan
   import cussen_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      clear_i,
   input  logic      scan_en_i,
   input  idx_t      lane_i,
   input  data_t     value_i,
   output lane_vec_t uniq_o,
   output ptr_vec_t  ptr_o,
   output idx_t      count_o
);

   lane_vec_t uniq_q;
   ptr_vec_t  ptr_q;
   idx_t      count_q;
   logic      hit;
   idx_t      hit_idx;

   // Lowest matching entry wins; only entries below count are valid.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = 0; k < LANES; k++) begin
         if (!hit && (idx_t'(k) < count_q) && (uniq_q[k] == value_i)) begin
            hit     = 1'b1;
            hit_idx = idx_t'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uniq_q  <= '0;
         ptr_q   <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (scan_en_i) begin
         if (hit) begin
            ptr_q[lane_i] <= hit_idx;
         end else begin
            uniq_q[count_q] <= value_i;
            ptr_q[lane_i]   <= count_q;
            count_q         <= count_q + 1'b1;
         end
      end
   end

   assign uniq_o  = uniq_q;
   assign ptr_o   = ptr_q;
   assign count_o = count_q;

endmodule

// File: rtl/cussen_repeat.sv
// Nine-lane vector-by-scalar multiplier that multiplies each distinct lane
// value once through a single shared multiplier, then fans results out.
module cussen_repeat
   import cussen_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   input  logic [DATA_W-1:0] in5,
   input  logic [DATA_W-1:0] in6,
   input  logic [DATA_W-1:0] in7,
   input  logic [DATA_W-1:0] in8,
   input  logic [DATA_W-1:0] in9,
   input  logic [DATA_W-1:0] scalar,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [DATA_W-1:0] out3,
   output logic [DATA_W-1:0] out4,
   output logic [DATA_W-1:0] out5,
   output logic [DATA_W-1:0] out6,
   output logic [DATA_W-1:0] out7,
   output logic [DATA_W-1:0] out8,
   output logic [DATA_W-1:0] out9,
   output logic [DATA_W-1:0] product,
   output logic [IDX_W-1:0]  unique_count
);

   logic [1:0] state_q, state_d;
   idx_t       idx_q, idx_d;
   lane_vec_t  snap_q, res_q, out_q;
   data_t      scalar_q, product_q;
   idx_t       ucount_q;
   lane_vec_t  uniq;
   ptr_vec_t   ptr;
   idx_t       count;
   data_t      mult_res;

   cussen_dedup_scan u_scan (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (state_q == StCapture),
      .scan_en_i (state_q == StScan),
      .lane_i    (idx_q),
      .value_i   (snap_q[idx_q]),
      .uniq_o    (uniq),
      .ptr_o     (ptr),
      .count_o   (count)
   );

   // Results are kept modulo 256, so an 8-bit product is exactly what is needed.
   assign mult_res = uniq[idx_q] * scalar_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         StCapture: begin
            state_d = StScan;
            idx_d   = '0;
         end
         StScan: begin
            if (idx_q == idx_t'(LANES - 1)) begin
               state_d = StMult;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StMult: begin
            if (idx_q == count - 1'b1) begin
               state_d = StWrite;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StWrite: state_d = StCapture;
         default: state_d = StCapture;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StCapture;
         idx_q     <= '0;
         snap_q    <= '0;
         scalar_q  <= '0;
         res_q     <= '0;
         out_q     <= '0;
         product_q <= '0;
         ucount_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (state_q == StCapture) begin
            snap_q   <= {in9, in8, in7, in6, in5, in4, in3, in2, in1};
            scalar_q <= scalar;
         end
         if (state_q == StMult) begin
            res_q[idx_q] <= mult_res;
            product_q    <= mult_res;
         end
         if (state_q == StWrite) begin
            for (int n = 0; n < LANES; n++) begin
               out_q[n] <= res_q[ptr[n]];
            end
            ucount_q <= count;
         end
      end
   end

   assign out1         = out_q[0];
   assign out2         = out_q[1];
   assign out3         = out_q[2];
   assign out4         = out_q[3];
   assign out5         = out_q[4];
   assign out6         = out_q[5];
   assign out7         = out_q[6];
   assign out8         = out_q[7];
   assign out9         = out_q[8];
   assign product      = product_q;
   assign unique_count = ucount_q;

endmodule

// File: tb/tb_cussen_repeat.sv
// Directed bench for cussen_repeat: a golden model pushes expected pass
// results to a queue, popped and compared at the edge the outputs update.
module tb_cussen_repeat;

   typedef logic [8:0][7:0] vec_t;
   typedef struct packed {
      vec_t       outs;
      logic [7:0] prod;
      logic [3:0] uc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   vec_t       in_v = '0;
   logic [7:0] scal = '0;
   logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8, o9, product;
   logic [3:0] unique_count;
   vec_t       out_v;
   exp_t       sb_q[$];
   exp_t       prev = '0;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   assign out_v = {o9, o8, o7, o6, o5, o4, o3, o2, o1};

   cussen_repeat dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in1          (in_v[0]),
      .in2          (in_v[1]),
      .in3          (in_v[2]),
      .in4          (in_v[3]),
      .in5          (in_v[4]),
      .in6          (in_v[5]),
      .in7          (in_v[6]),
      .in8          (in_v[7]),
      .in9          (in_v[8]),
      .scalar       (scal),
      .out1         (o1),
      .out2         (o2),
      .out3         (o3),
      .out4         (o4),
      .out5         (o5),
      .out6         (o6),
      .out7         (o7),
      .out8         (o8),
      .out9         (o9),
      .product      (product),
      .unique_count (unique_count)
   );

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic vec_t mk(input int a, b, c, d, e, f, g, h, i);
      vec_t v;
      v[0] = 8'(a); v[1] = 8'(b); v[2] = 8'(c); v[3] = 8'(d); v[4] = 8'(e);
      v[5] = 8'(f); v[6] = 8'(g); v[7] = 8'(h); v[8] = 8'(i);
      return v;
   endfunction

   function automatic exp_t model(input vec_t v, input logic [7:0] s);
      exp_t        e;
      logic [7:0]  u[9];
      logic [15:0] p;
      int          n = 0;
      bit          seen;
      e = '0;
      for (int i = 0; i < 9; i++) begin
         p         = v[i] * s;
         e.outs[i] = p[7:0];
         seen      = 1'b0;
         for (int k = 0; k < n; k++) if (u[k] == v[i]) seen = 1'b1;
         if (!seen) begin
            u[n] = v[i];
            n++;
         end
      end
      p      = u[n-1] * s;
      e.prod = p[7:0];
      e.uc   = 4'(n);
      return e;
   endfunction

   // Caller guarantees the next rising edge is a CAPTURE edge.
   task automatic run_pass(input string tag, input vec_t v, input logic [7:0] s,
                           input bit mid, input vec_t mv, input logic [7:0] ms);
      exp_t e;
      exp_t got;
      int   u;
      in_v = v;
      scal = s;
      e    = model(v, s);
      sb_q.push_back(e);
      u    = int'(e.uc);
      @(posedge clk);
      #1;
      if (mid) begin
         in_v = mv;
         scal = ms;
      end
      repeat (9 + u) @(posedge clk);
      #1;
      chk({tag, "_hold_outs"}, 72'(out_v), 72'(prev.outs));
      chk({tag, "_hold_uc"}, 72'(unique_count), 72'(prev.uc));
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      for (int n = 0; n < 9; n++) begin
         chk($sformatf("%s_out%0d", tag, n + 1), 72'(out_v[n]), 72'(got.outs[n]));
      end
      chk({tag, "_product"}, 72'(product), 72'(got.prod));
      chk({tag, "_uc"}, 72'(unique_count), 72'(got.uc));
      prev = got;
   endtask

   initial begin
      vec_t nv;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", 72'(out_v), 72'(0));
      chk("rst_product", 72'(product), 72'(0));
      chk("rst_uc", 72'(unique_count), 72'(0));
      @(negedge clk);
      rst_n = 1'b1;

      run_pass("all9", mk(9, 9, 9, 9, 9, 9, 9, 9, 9), 8'd9, 1'b0, '0, '0);
      run_pass("distinct", mk(5, 3, 8, 1, 2, 9, 7, 6, 4), 8'd2, 1'b0, '0, '0);
      nv = mk(0, 255, 0, 17, 17, 255, 128, 3, 0);
      run_pass("repeats", mk(3, 1, 4, 1, 5, 9, 1, 1, 1), 8'd2, 1'b1, nv, 8'd3);
      run_pass("late_in", nv, 8'd3, 1'b0, '0, '0);
      run_pass("wrap", mk(20, 20, 20, 20, 20, 20, 20, 20, 20), 8'd20, 1'b0, '0, '0);

      // Abort a pass while it is multiplying.
      in_v = mk(11, 12, 13, 14, 15, 16, 17, 18, 19);
      scal = 8'd7;
      @(posedge clk);
      repeat (11) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", 72'(out_v), 72'(0));
      chk("midrst_product", 72'(product), 72'(0));
      chk("midrst_uc", 72'(unique_count), 72'(0));
      @(negedge clk);
      rst_n = 1'b1;
      prev  = '0;

      run_pass("after_rst", mk(200, 100, 200, 50, 0, 0, 100, 7, 255), 8'd13, 1'b0, '0, '0);
      run_pass("scalar0", mk(1, 2, 3, 0, 5, 6, 7, 8, 9), 8'd0, 1'b0, '0, '0);

      chk("sb_empty", 72'(sb_q.size()), 72'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
